// File: rtl/router_req_sequencer.sv
// router_req_sequencer: N_CH one-deep request slots granted round-robin
// onto the router start/ack handshake; SEQ_TIMEOUT_EN adds timeout/retry.
module router_req_sequencer #(
  parameter int N_CH        = 4,
  parameter int ADDR_W      = 10,
  parameter int DFX_W       = 2,
  parameter int TIMEOUT_CYC = 200,
  parameter int MAX_RETRY   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        ch_valid,
  output logic [N_CH-1:0]        ch_ready,
  input  logic [N_CH*ADDR_W-1:0] ch_src_addr,
  input  logic [N_CH*ADDR_W-1:0] ch_dst_addr,
  input  logic [N_CH*DFX_W-1:0]  ch_src_dfx,
  input  logic [N_CH*DFX_W-1:0]  ch_dst_dfx,
  output logic [N_CH-1:0]        ch_done,
  output logic [N_CH-1:0]        ch_err,
  output logic                   router_start_req,
  output logic [ADDR_W-1:0]      router_src_addr,
  output logic [ADDR_W-1:0]      router_dst_addr,
  output logic [DFX_W-1:0]       router_src_dfx,
  output logic [DFX_W-1:0]       router_dst_dfx,
  input  logic                   router_ack
);

  localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;

  if (N_CH < 2 || N_CH > 8 || TIMEOUT_CYC < 2 || MAX_RETRY < 0)
  begin : g_bad_param
    $error("router_req_sequencer: parameter out of range");
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_BACKOFF} state_e;
`else
  typedef enum logic [0:0] {S_IDLE, S_REQ} state_e;
`endif

  state_e state_q, state_d;

  logic [PW-1:0] rr_q, rr_d;
  logic [PW-1:0] gnt_q, gnt_d;
  logic [N_CH-1:0] full_q, full_d;
  logic [ADDR_W-1:0] src_q [N_CH];
  logic [ADDR_W-1:0] src_d [N_CH];
  logic [ADDR_W-1:0] dst_q [N_CH];
  logic [ADDR_W-1:0] dst_d [N_CH];
  logic [DFX_W-1:0] sdfx_q [N_CH];
  logic [DFX_W-1:0] sdfx_d [N_CH];
  logic [DFX_W-1:0] ddfx_q [N_CH];
  logic [DFX_W-1:0] ddfx_d [N_CH];

  logic req_q, req_d;
  logic [ADDR_W-1:0] r_src_q, r_src_d;
  logic [ADDR_W-1:0] r_dst_q, r_dst_d;
  logic [DFX_W-1:0] r_sdfx_q, r_sdfx_d;
  logic [DFX_W-1:0] r_ddfx_q, r_ddfx_d;
  logic [N_CH-1:0] done_q, done_d;
  logic [N_CH-1:0] err_q, err_d;

`ifdef SEQ_TIMEOUT_EN
  logic [TW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rty_q, rty_d;
  logic bo_q, bo_d;
`endif

  logic found;
  logic [PW-1:0] pick;
  logic [PW-1:0] nxt;
  logic [PW:0] idx;
  logic [PW:0] inc;
  logic degen;

  // First full slot at or after rr_q, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = {1'b0, rr_q} + (PW+1)'(k);
      if (idx >= (PW+1)'(N_CH))
        idx = idx - (PW+1)'(N_CH);
      if (!found && full_q[idx[PW-1:0]]) begin
        found = 1'b1;
        pick  = idx[PW-1:0];
      end
    end
    inc = {1'b0, pick} + (PW+1)'(1);
    if (inc >= (PW+1)'(N_CH))
      nxt = '0;
    else
      nxt = inc[PW-1:0];
    degen = (src_q[pick] == dst_q[pick]) &&
            (sdfx_q[pick] == ddfx_q[pick]);
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    gnt_d    = gnt_q;
    full_d   = full_q;
    src_d    = src_q;
    dst_d    = dst_q;
    sdfx_d   = sdfx_q;
    ddfx_d   = ddfx_q;
    req_d    = req_q;
    r_src_d  = r_src_q;
    r_dst_d  = r_dst_q;
    r_sdfx_d = r_sdfx_q;
    r_ddfx_d = r_ddfx_q;
    done_d   = '0;
    err_d    = '0;
`ifdef SEQ_TIMEOUT_EN
    cnt_d    = cnt_q;
    rty_d    = rty_q;
    bo_d     = bo_q;
`endif

    for (int i = 0; i < N_CH; i++) begin
      if (ch_valid[i] && !full_q[i]) begin
        full_d[i] = 1'b1;
        src_d[i]  = ch_src_addr[i*ADDR_W +: ADDR_W];
        dst_d[i]  = ch_dst_addr[i*ADDR_W +: ADDR_W];
        sdfx_d[i] = ch_src_dfx[i*DFX_W +: DFX_W];
        ddfx_d[i] = ch_dst_dfx[i*DFX_W +: DFX_W];
      end
    end

    // Clears only target full slots, so they never collide with loads.
    case (state_q)
      S_IDLE: begin
        if (found) begin
          rr_d = nxt;
          if (degen) begin
            err_d[pick]  = 1'b1;
            full_d[pick] = 1'b0;
          end else begin
            gnt_d    = pick;
            req_d    = 1'b1;
            r_src_d  = src_q[pick];
            r_dst_d  = dst_q[pick];
            r_sdfx_d = sdfx_q[pick];
            r_ddfx_d = ddfx_q[pick];
            state_d  = S_REQ;
`ifdef SEQ_TIMEOUT_EN
            cnt_d    = '0;
            rty_d    = '0;
`endif
          end
        end
      end
      S_REQ: begin
        if (router_ack) begin
          req_d         = 1'b0;
          done_d[gnt_q] = 1'b1;
          full_d[gnt_q] = 1'b0;
          state_d       = S_IDLE;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (cnt_q == TW'(TIMEOUT_CYC - 1)) begin
          req_d = 1'b0;
          if (rty_q < RW'(MAX_RETRY)) begin
            rty_d   = rty_q + RW'(1);
            bo_d    = 1'b0;
            state_d = S_BACKOFF;
          end else begin
            err_d[gnt_q]  = 1'b1;
            full_d[gnt_q] = 1'b0;
            state_d       = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
`endif
      end
`ifdef SEQ_TIMEOUT_EN
      S_BACKOFF: begin
        if (bo_q) begin
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_REQ;
        end else begin
          bo_d = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_q     <= '0;
      gnt_q    <= '0;
      full_q   <= '0;
      src_q    <= '{default: '0};
      dst_q    <= '{default: '0};
      sdfx_q   <= '{default: '0};
      ddfx_q   <= '{default: '0};
      req_q    <= 1'b0;
      r_src_q  <= '0;
      r_dst_q  <= '0;
      r_sdfx_q <= '0;
      r_ddfx_q <= '0;
      done_q   <= '0;
      err_q    <= '0;
`ifdef SEQ_TIMEOUT_EN
      cnt_q    <= '0;
      rty_q    <= '0;
      bo_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      gnt_q    <= gnt_d;
      full_q   <= full_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      sdfx_q   <= sdfx_d;
      ddfx_q   <= ddfx_d;
      req_q    <= req_d;
      r_src_q  <= r_src_d;
      r_dst_q  <= r_dst_d;
      r_sdfx_q <= r_sdfx_d;
      r_ddfx_q <= r_ddfx_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef SEQ_TIMEOUT_EN
      cnt_q    <= cnt_d;
      rty_q    <= rty_d;
      bo_q     <= bo_d;
`endif
    end
  end

  assign ch_ready         = ~full_q;
  assign ch_done          = done_q;
  assign ch_err           = err_q;
  assign router_start_req = req_q;
  assign router_src_addr  = r_src_q;
  assign router_dst_addr  = r_dst_q;
  assign router_src_dfx   = r_sdfx_q;
  assign router_dst_dfx   = r_ddfx_q;

endmodule

// File: tb/tb_router_req_sequencer.sv
// Directed bench for router_req_sequencer with an issue-order scoreboard.
// Timeout/retry steps run only when SEQ_TIMEOUT_EN is defined.
module tb_router_req_sequencer;

  localparam int N_CH   = 4;
  localparam int ADDR_W = 10;
  localparam int DFX_W  = 2;

  logic clk = 1'b0;
  logic rst;
  logic [N_CH-1:0] ch_valid;
  logic [N_CH-1:0] ch_ready;
  logic [N_CH*ADDR_W-1:0] ch_src_addr;
  logic [N_CH*ADDR_W-1:0] ch_dst_addr;
  logic [N_CH*DFX_W-1:0] ch_src_dfx;
  logic [N_CH*DFX_W-1:0] ch_dst_dfx;
  logic [N_CH-1:0] ch_done;
  logic [N_CH-1:0] ch_err;
  logic router_start_req;
  logic [ADDR_W-1:0] router_src_addr;
  logic [ADDR_W-1:0] router_dst_addr;
  logic [DFX_W-1:0] router_src_dfx;
  logic [DFX_W-1:0] router_dst_dfx;
  logic router_ack;

  typedef struct packed {
    logic [1:0] ch;
    logic [9:0] src;
    logic [9:0] dst;
    logic [1:0] sd;
    logic [1:0] dd;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  router_req_sequencer #(
    .N_CH(N_CH), .ADDR_W(ADDR_W), .DFX_W(DFX_W),
    .TIMEOUT_CYC(8), .MAX_RETRY(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ch_valid(ch_valid),
    .ch_ready(ch_ready),
    .ch_src_addr(ch_src_addr),
    .ch_dst_addr(ch_dst_addr),
    .ch_src_dfx(ch_src_dfx),
    .ch_dst_dfx(ch_dst_dfx),
    .ch_done(ch_done),
    .ch_err(ch_err),
    .router_start_req(router_start_req),
    .router_src_addr(router_src_addr),
    .router_dst_addr(router_dst_addr),
    .router_src_dfx(router_src_dfx),
    .router_dst_dfx(router_dst_dfx),
    .router_ack(router_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic [9:0] s,
                        input logic [9:0] d, input logic [1:0] sd,
                        input logic [1:0] dd);
    exp_t e;
    ch_valid[ch] = 1'b1;
    ch_src_addr[ch*ADDR_W +: ADDR_W] = s;
    ch_dst_addr[ch*ADDR_W +: ADDR_W] = d;
    ch_src_dfx[ch*DFX_W +: DFX_W] = sd;
    ch_dst_dfx[ch*DFX_W +: DFX_W] = dd;
    e = '{ch: 2'(ch), src: s, dst: d, sd: sd, dd: dd};
    if (!(s == d && sd == dd)) q.push_back(e);
  endtask

  task automatic commit();
    @(posedge clk);
    #1 ch_valid = '0;
  endtask

  task automatic wait_issue(output exp_t e);
    int n;
    n = 0;
    @(negedge clk);
    while (!router_start_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("issue_seen", 32'(router_start_req), 32'd1);
    chk("sb_pending", 32'(q.size() != 0), 32'd1);
    if (q.size() != 0) e = q.pop_front();
    else e = '0;
    chk("issue_src", 32'(router_src_addr), 32'(e.src));
    chk("issue_dst", 32'(router_dst_addr), 32'(e.dst));
    chk("issue_sdfx", 32'(router_src_dfx), 32'(e.sd));
    chk("issue_ddfx", 32'(router_dst_dfx), 32'(e.dd));
  endtask

  task automatic finish_ack(input exp_t e, input int dly);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("hold_req", 32'(router_start_req), 32'd1);
      chk("hold_src", 32'(router_src_addr), 32'(e.src));
      chk("hold_dfx", 32'({router_src_dfx, router_dst_dfx}),
          32'({e.sd, e.dd}));
    end
    router_ack = 1'b1;
    @(posedge clk);
    #1 router_ack = 1'b0;
    @(negedge clk);
    chk("ack_req_low", 32'(router_start_req), 32'd0);
    chk("ack_done", 32'(ch_done), 32'(4'b0001 << e.ch));
    chk("ack_no_err", 32'(ch_err), 32'd0);
    chk("ack_ready", 32'(ch_ready[e.ch]), 32'd1);
    @(negedge clk);
    chk("done_pulse_end", 32'(ch_done), 32'd0);
  endtask

  task automatic serve(input int dly);
    exp_t e;
    wait_issue(e);
    finish_ack(e, dly);
  endtask

`ifdef SEQ_TIMEOUT_EN
  task automatic count_high(output int hi);
    hi = 0;
    while (router_start_req && hi < 50) begin
      hi++;
      @(negedge clk);
    end
  endtask

  task automatic count_low(output int lo);
    lo = 0;
    while (!router_start_req && lo < 20) begin
      lo++;
      @(negedge clk);
    end
  endtask

  task automatic expect_fail(input exp_t e);
    int hi;
    int lo;
    for (int b = 0; b < 3; b++) begin
      count_high(hi);
      chk("to_burst_len", 32'(hi), 32'd8);
      chk("to_err", 32'(ch_err),
          (b == 2) ? 32'(4'b0001 << e.ch) : 32'd0);
      if (b < 2) begin
        count_low(lo);
        chk("to_gap_len", 32'(lo), 32'd2);
        chk("to_reissue_src", 32'(router_src_addr), 32'(e.src));
      end
    end
    chk("to_slot_free", 32'(ch_ready[e.ch]), 32'd1);
    @(negedge clk);
    chk("to_err_end", 32'(ch_err), 32'd0);
    chk("to_no_req", 32'(router_start_req), 32'd0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic quiet;
`ifdef SEQ_TIMEOUT_EN
    int hi;
    int lo;
`endif
    rst = 1'b1;
    ch_valid = '0;
    ch_src_addr = '0;
    ch_dst_addr = '0;
    ch_src_dfx = '0;
    ch_dst_dfx = '0;
    router_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(router_start_req), 32'd0);
    chk("rst_fields", 32'({router_src_addr, router_dst_addr,
        router_src_dfx, router_dst_dfx}), 32'd0);
    chk("rst_ready", 32'(ch_ready), 32'hf);
    chk("rst_done_err", 32'({ch_done, ch_err}), 32'd0);
    rst = 1'b0;

    // Single request, ack three cycles after start_req.
    @(negedge clk);
    set_ch(0, 10'h001, 10'h005, 2'b01, 2'b10);
    commit();
    @(negedge clk);
    chk("load_ready_low", 32'(ch_ready[0]), 32'd0);
    chk("no_early_req", 32'(router_start_req), 32'd0);
    serve(3);

    // Round-robin from a fresh pointer.
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    set_ch(0, 10'h011, 10'h012, 2'd0, 2'd3);
    set_ch(1, 10'h021, 10'h022, 2'd1, 2'd2);
    set_ch(2, 10'h031, 10'h032, 2'd2, 2'd1);
    set_ch(3, 10'h041, 10'h042, 2'd3, 2'd0);
    commit();
    for (int i = 0; i < 4; i++) serve(1);
    @(negedge clk);
    set_ch(1, 10'h121, 10'h122, 2'd1, 2'd0);
    commit();
    serve(1);
    @(negedge clk);
    set_ch(2, 10'h231, 10'h232, 2'd0, 2'd1);
    set_ch(0, 10'h211, 10'h212, 2'd3, 2'd3);
    commit();
    serve(1);
    serve(0);

    // Degenerate request is rejected without a router request.
    @(negedge clk);
    set_ch(3, 10'h005, 10'h005, 2'b01, 2'b01);
    commit();
    @(negedge clk);
    chk("degen_err_wait", 32'(ch_err), 32'd0);
    @(negedge clk);
    chk("degen_err", 32'(ch_err), 32'h8);
    chk("degen_no_req", 32'(router_start_req), 32'd0);
    chk("degen_ready", 32'(ch_ready[3]), 32'd1);
    @(negedge clk);
    chk("degen_err_end", 32'(ch_err), 32'd0);
    chk("degen_still_idle", 32'(router_start_req), 32'd0);

    // Same address but different DFX is a legal request.
    set_ch(3, 10'h005, 10'h005, 2'b01, 2'b10);
    commit();
    serve(0);

    // Ack outside REQ has no effect.
    @(negedge clk) router_ack = 1'b1;
    @(posedge clk);
    #1 router_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_done", 32'(ch_done), 32'd0);
    chk("idle_ack_req", 32'(router_start_req), 32'd0);

    // Asynchronous reset while a request is outstanding.
    set_ch(1, 10'h3a1, 10'h3a2, 2'd2, 2'd2);
    commit();
    wait_issue(e);
    #2 rst = 1'b1;
    #1;
    chk("arst_req", 32'(router_start_req), 32'd0);
    chk("arst_ready", 32'(ch_ready), 32'hf);
    @(negedge clk) rst = 1'b0;
    quiet = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      quiet = quiet | router_start_req | (|ch_done) | (|ch_err);
    end
    chk("post_rst_quiet", 32'(quiet), 32'd0);
    set_ch(0, 10'h101, 10'h102, 2'd1, 2'd1);
    set_ch(2, 10'h201, 10'h202, 2'd2, 2'd0);
    commit();
    serve(0);
    serve(2);

`ifdef SEQ_TIMEOUT_EN
    // Never acked: three bursts, then error.
    @(negedge clk);
    set_ch(2, 10'h0a0, 10'h0b0, 2'd1, 2'd2);
    commit();
    wait_issue(e);
    expect_fail(e);

    // Ack on the second issue.
    set_ch(0, 10'h0c0, 10'h0d0, 2'd3, 2'd1);
    commit();
    wait_issue(e);
    count_high(hi);
    chk("late_burst_len", 32'(hi), 32'd8);
    count_low(lo);
    chk("late_gap_len", 32'(lo), 32'd2);
    finish_ack(e, 2);

    // Retry budget starts fresh for the next grant.
    set_ch(1, 10'h0e0, 10'h0f0, 2'd0, 2'd2);
    commit();
    wait_issue(e);
    expect_fail(e);
`endif

    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/router_req_sequencer.md
# router_req_sequencer

Parametrised, multi-channel successor to the single-shot router request path. It accepts up to N_CH independent route requests (source/destination address plus DFX region IDs) and holds each in a one-deep per-channel slot. It grants slots round-robin and drives one request at a time onto the router's start_req/ack handshake. It reports per-channel completion, with optional timeout/retry. It sits between request generators (or the system testbench) and the router core's start-request inputs.

## Interface
- N_CH, 4: number of request channels (2..8)
- ADDR_W, 10: router address width
- DFX_W, 2: DFX region ID width
- TIMEOUT_CYC, 200: cycles in REQ without ack before timeout (needs SEQ_TIMEOUT_EN)
- MAX_RETRY, 2: reissues after first timeout before error
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- ch_valid  in  N_CH  per-channel request valid
- ch_ready  out  N_CH  per-channel slot empty
- ch_src_addr  in  N_CH*ADDR_W  packed source addresses, channel i at [i*ADDR_W +: ADDR_W]
- ch_dst_addr  in  N_CH*ADDR_W  packed destination addresses
- ch_src_dfx  in  N_CH*DFX_W  packed source DFX IDs
- ch_dst_dfx  in  N_CH*DFX_W  packed destination DFX IDs
- ch_done  out  N_CH  one-cycle pulse: channel request acked
- ch_err  out  N_CH  one-cycle pulse: channel request failed
- router_start_req  out  1  request to router, held until ack
- router_src_addr / router_dst_addr  out  ADDR_W  granted request addresses
- router_src_dfx / router_dst_dfx  out  DFX_W  granted request DFX IDs
- router_ack  in  1  router accepts current request (sampled only in REQ)

## Operation
- Slot i loads on ch_valid[i] & ch_ready[i]. ch_ready[i] = ~slot_full[i]. The slot clears only on that channel's done or err.
- FSM states: IDLE, REQ, BACKOFF.
- IDLE: if any slot is full and not yet granted, pick the first full slot at or after rr_ptr (wrapping). Then:
  - Register its fields onto the router_* outputs.
  - Set router_start_req = 1, go to REQ.
  - Set rr_ptr = grant+1 mod N_CH.
  - Clear the timeout count and retry count.
- Degenerate request (src_addr == dst_addr and src_dfx == dst_dfx): not issued. In IDLE, ch_err pulses, the slot clears, and rr_ptr advances.
- REQ: router_start_req and all router_* fields stay stable.
  - router_ack = 1 → start_req = 0, ch_done[grant] pulses, slot clears, go to IDLE.
- REQ timeout (SEQ_TIMEOUT_EN): the counter reaches TIMEOUT_CYC - 1 without ack.
  - If retries < MAX_RETRY: start_req = 0, retries+1, go to BACKOFF.
  - Otherwise: ch_err[grant] pulses, slot clears, go to IDLE.
- BACKOFF: start_req stays low for exactly 2 cycles. Then reassert with the same fields, counter cleared, state REQ.
- Reset values:
  - router_start_req = 0.
  - All router_* fields = 0.
  - ch_done = 0, ch_err = 0.
  - ch_ready = all 1s.
  - State IDLE, rr_ptr = 0.

## Timing
- All outputs are registered.
- Accept at edge N → ch_ready[i] low after N. The earliest router_start_req high is after edge N+1.
- Ack sampled at edge M:
  - start_req low after M.
  - ch_done high for exactly the cycle after M.
  - ch_ready[grant] high after M.
  - Next start_req at earliest after M+1, so there is always at least one low cycle between requests.
- Ack on the same edge as timeout expiry: ack wins (done, not retry/err).
- Ack during BACKOFF or IDLE is ignored.
- A channel cannot reload on the edge its done/err fires; ch_ready is still low at that edge.
- Timeout-to-reissue: expiry at edge T, start_req low for 2 cycles, high again after T+2.
- Asynchronous rst mid-REQ:
  - start_req drops immediately.
  - All slots are discarded; no done/err is generated.
  - After release, the block behaves as if from power-up.
- Round-robin fairness: with all N_CH slots continuously refilled, each channel is granted once per N_CH grants.

## Configuration
- SEQ_TIMEOUT_EN defined: the timeout counter ($clog2(TIMEOUT_CYC) bits), retry counter and BACKOFF state are compiled in, with the behaviour above.
- SEQ_TIMEOUT_EN undefined:
  - REQ waits indefinitely for router_ack; BACKOFF is unreachable and removed.
  - ch_err pulses only for degenerate requests.
  - TIMEOUT_CYC and MAX_RETRY are unused.

## Test plan
- Single request: ch0 loads src 0x001, dst 0x005, src_dfx 01, dst_dfx 10; router_ack 3 cycles after start_req → outputs carry 0x001/0x005/01/10 while start_req is high, and ch_done[0] pulses once.
- Round-robin: all 4 channels load in one cycle, router acks each request after 1 cycle → grant order 0,1,2,3, then after ch1 reload the order is 1.
- Timeout/retry (macro on, TIMEOUT_CYC 8, MAX_RETRY 2), ack never asserted → 3 start_req bursts of 8 cycles separated by 2 low cycles, then ch_err pulse, slot freed.
- Late ack on retry: ack on the 2nd issue → ch_done, no ch_err, retry count resets for the next grant.
- Degenerate request src = dst = 0x005, dfx 01/01 → ch_err pulse, no start_req.
- Reset mid-REQ: rst high while start_req is high → start_req low asynchronously, ch_ready all 1s, no done/err pulse after release.
